// File: rtl/im2col_stream_scheduler.sv
// Layer-level sequencer for one im2col converter: validates the layer shape, derives the
// converter's jump constants and walks one converter stream per channel of the stacked ifmap.
module im2col_stream_scheduler #(
    parameter int FILTER_SIZE = 5,
    parameter int VECTOR_ROWS = 4,
    parameter int ADDR_W      = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [5:0]        cfg_ifmap_size,
    input  logic [4:0]        cfg_num_channels,
    output logic              busy,
    output logic              cfg_error,
    output logic              done,
    output logic [3:0]        channel_idx,
    output logic              conv_reset,
    output logic              conv_enable,
    output logic [9:0]        conv_ifmap_len,
    output logic [4:0]        conv_ofmap_size,
    output logic [9:0]        conv_next_weight_row_jump,
    output logic [9:0]        conv_next_ifmap_row_jump,
    output logic [9:0]        conv_next_vector_jump,
    input  logic [9:0]        conv_read_psum_addr,
    input  logic              conv_stream_done,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam int VR_SHIFT = $clog2(VECTOR_ROWS);

    logic [2:0]        state;
    logic [5:0]        size_q;
    logic [4:0]        nch_q;
    logic [ADDR_W-1:0] base;
    logic              stream_done_q;
    logic              last_channel;
    int                size_i;

    function automatic logic cfg_legal(input logic [5:0] size, input logic [4:0] nch);
        int s;
        int n;
        s = int'(size);
        n = int'(nch);
        return (s >= 8) && (s <= 32) && ((s % VECTOR_ROWS) == 0) && (n >= 1) && (n <= 16);
    endfunction

    assign size_i       = int'(size_q);
    assign last_channel = ({1'b0, channel_idx} == (nch_q - 5'd1));
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_FIN);
    // The converter only advances while streaming; the cycle after its done is a drain cycle.
    assign conv_enable  = (state == S_RUN) && !stream_done_q;
    assign conv_reset   = reset || abort || (state == S_IDLE) || (state == S_GAP) || (state == S_FIN);

    always_ff @(posedge clock) begin
        if (reset) begin
            state                     <= S_IDLE;
            size_q                    <= '0;
            nch_q                     <= '0;
            base                      <= '0;
            stream_done_q             <= 1'b0;
            cfg_error                 <= 1'b0;
            channel_idx               <= '0;
            rd_addr                   <= '0;
            rd_valid                  <= 1'b0;
            conv_ifmap_len            <= '0;
            conv_ofmap_size           <= '0;
            conv_next_weight_row_jump <= '0;
            conv_next_ifmap_row_jump  <= '0;
            conv_next_vector_jump     <= '0;
        end else if (abort) begin
            state         <= S_IDLE;
            stream_done_q <= 1'b0;
            cfg_error     <= 1'b0;
            rd_valid      <= 1'b0;
        end else begin
            cfg_error <= 1'b0;
            rd_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        size_q <= cfg_ifmap_size;
                        nch_q  <= cfg_num_channels;
                        if (cfg_legal(cfg_ifmap_size, cfg_num_channels)) begin
                            state       <= S_CALC;
                            channel_idx <= '0;
                            base        <= '0;
                        end else begin
                            cfg_error <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    conv_ifmap_len            <= 10'(size_i * size_i - 1);
                    conv_ofmap_size           <= 5'((size_i - VECTOR_ROWS) >> VR_SHIFT);
                    conv_next_weight_row_jump <= 10'(size_i - (FILTER_SIZE - 1 + VECTOR_ROWS - 1));
                    conv_next_ifmap_row_jump  <= 10'(size_i * FILTER_SIZE - 1 - size_i);
                    conv_next_vector_jump     <= 10'((FILTER_SIZE - 1) * (size_i + 1) + VECTOR_ROWS - 1 - VECTOR_ROWS);
                    state                     <= S_RUN;
                end
                S_RUN: begin
                    if (!stream_done_q) begin
                        rd_valid      <= 1'b1;
                        rd_addr       <= base + ADDR_W'(conv_read_psum_addr);
                        stream_done_q <= conv_stream_done;
                    end else begin
                        stream_done_q <= 1'b0;
                        state         <= last_channel ? S_FIN : S_GAP;
                    end
                end
                S_GAP: begin
                    channel_idx <= channel_idx + 4'd1;
                    base        <= base + ADDR_W'(conv_ifmap_len) + ADDR_W'(1);
                    state       <= S_RUN;
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im2col_stream_scheduler.sv
// Directed bench for im2col_stream_scheduler with a behavioural converter stub that counts
// 0..conv_ifmap_len while enabled and flags its last address.
module tb_im2col_stream_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  cfg_ifmap_size = '0;
    logic [4:0]  cfg_num_channels = '0;
    logic        busy, cfg_error, done, conv_reset, conv_enable, conv_stream_done, rd_valid;
    logic [3:0]  channel_idx;
    logic [9:0]  conv_ifmap_len, conv_next_weight_row_jump, conv_next_ifmap_row_jump, conv_next_vector_jump;
    logic [4:0]  conv_ofmap_size;
    logic [9:0]  conv_read_psum_addr;
    logic [13:0] rd_addr;
    logic [9:0]  stub_addr;

    int checks = 0;
    int failures = 0;

    int s_nvalid, s_addr_err, s_chan_err, s_bubbles, s_bubble_err, s_ndone;
    int s_first_valid, s_last_valid, s_done_cyc, s_end_cyc, s_cfg_err_seen, s_timeout;

    always #5 clock = ~clock;

    im2col_stream_scheduler #(.FILTER_SIZE(5), .VECTOR_ROWS(4), .ADDR_W(14)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .cfg_ifmap_size(cfg_ifmap_size), .cfg_num_channels(cfg_num_channels),
        .busy(busy), .cfg_error(cfg_error), .done(done), .channel_idx(channel_idx),
        .conv_reset(conv_reset), .conv_enable(conv_enable),
        .conv_ifmap_len(conv_ifmap_len), .conv_ofmap_size(conv_ofmap_size),
        .conv_next_weight_row_jump(conv_next_weight_row_jump),
        .conv_next_ifmap_row_jump(conv_next_ifmap_row_jump),
        .conv_next_vector_jump(conv_next_vector_jump),
        .conv_read_psum_addr(conv_read_psum_addr), .conv_stream_done(conv_stream_done),
        .rd_addr(rd_addr), .rd_valid(rd_valid)
    );

    always @(posedge clock) begin
        if (conv_reset) stub_addr <= '0;
        else if (conv_enable && stub_addr != conv_ifmap_len) stub_addr <= stub_addr + 10'd1;
    end
    assign conv_read_psum_addr = stub_addr;
    assign conv_stream_done    = conv_enable && (stub_addr == conv_ifmap_len);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input int size, input int nch);
        start            = 1'b1;
        cfg_ifmap_size   = 6'(size);
        cfg_num_channels = 5'(nch);
        tick();
        start = 1'b0;
    endtask

    // Observes the stream from the cycle after CALC until busy falls or the budget runs out.
    task automatic scan(input int size, input int budget, input bit poke);
        int gap;
        bit seen;
        s_nvalid = 0; s_addr_err = 0; s_chan_err = 0; s_bubbles = 0; s_bubble_err = 0;
        s_ndone = 0; s_first_valid = -1; s_last_valid = -1; s_done_cyc = -1; s_end_cyc = -1;
        s_cfg_err_seen = 0; s_timeout = 1; gap = 0; seen = 0;
        for (int k = 1; k <= budget; k++) begin
            if (poke && (k % 300) == 150) begin
                start = 1'b1; cfg_ifmap_size = 6'd30; cfg_num_channels = 5'd1;
            end
            tick();
            start = 1'b0;
            if (cfg_error) s_cfg_err_seen++;
            if (rd_valid) begin
                if (s_first_valid < 0) s_first_valid = k;
                if (int'(rd_addr) != s_nvalid) s_addr_err++;
                if (int'(channel_idx) != s_nvalid / (size * size)) s_chan_err++;
                if (seen && gap != 0) begin
                    s_bubbles++;
                    if (gap != 2) s_bubble_err++;
                end
                gap = 0; seen = 1; s_nvalid++; s_last_valid = k;
            end else if (seen) begin
                gap++;
            end
            if (done) begin s_ndone++; s_done_cyc = k; end
            if (!busy) begin s_end_cyc = k; s_timeout = 0; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0 || cfg_error !== 1'b0) begin failures++; $display("FAIL reset_flags got busy=%b done=%b err=%b required 0/0/0", busy, done, cfg_error); end
        checks++; if (conv_enable !== 1'b0 || rd_valid !== 1'b0 || conv_reset !== 1'b1) begin failures++; $display("FAIL reset_conv got en=%b vld=%b crst=%b required 0/0/1", conv_enable, rd_valid, conv_reset); end
        checks++; if (channel_idx !== 4'd0 || rd_addr !== 14'd0 || conv_ifmap_len !== 10'd0 || conv_ofmap_size !== 5'd0) begin failures++; $display("FAIL reset_values got ch=%0d addr=%0d len=%0d ofm=%0d required 0", channel_idx, rd_addr, conv_ifmap_len, conv_ofmap_size); end
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || conv_reset !== 1'b1) begin failures++; $display("FAIL idle_after_reset got busy=%b crst=%b required 0/1", busy, conv_reset); end
    endtask

    task automatic test_legal_28();
        pulse_start(28, 1);
        checks++; if (busy !== 1'b1 || conv_enable !== 1'b0) begin failures++; $display("FAIL calc_28 got busy=%b en=%b required 1/0", busy, conv_enable); end
        tick();
        checks++; if (conv_enable !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL run_entry_28 got en=%b vld=%b required 1/0", conv_enable, rd_valid); end
        checks++; if (conv_ifmap_len !== 10'd783 || conv_ofmap_size !== 5'd6) begin failures++; $display("FAIL len_ofm_28 got %0d/%0d required 783/6", conv_ifmap_len, conv_ofmap_size); end
        checks++; if (conv_next_weight_row_jump !== 10'd21 || conv_next_ifmap_row_jump !== 10'd111 || conv_next_vector_jump !== 10'd115) begin failures++; $display("FAIL jumps_28 got %0d/%0d/%0d required 21/111/115", conv_next_weight_row_jump, conv_next_ifmap_row_jump, conv_next_vector_jump); end
        scan(28, 1000, 1'b0);
        checks++; if (s_timeout !== 0) begin failures++; $display("FAIL timeout_28 got %0d required 0", s_timeout); end
        checks++; if (s_first_valid !== 1) begin failures++; $display("FAIL first_valid_28 got %0d required 1", s_first_valid); end
        checks++; if (s_nvalid !== 784 || s_addr_err !== 0) begin failures++; $display("FAIL stream_28 got n=%0d errs=%0d required 784/0", s_nvalid, s_addr_err); end
        checks++; if (s_ndone !== 1 || s_done_cyc !== s_last_valid + 1) begin failures++; $display("FAIL done_28 got n=%0d at %0d required 1 at %0d", s_ndone, s_done_cyc, s_last_valid + 1); end
        checks++; if (s_end_cyc !== s_done_cyc + 1) begin failures++; $display("FAIL busy_fall_28 got %0d required %0d", s_end_cyc, s_done_cyc + 1); end
        checks++; if (rd_addr !== 14'd783) begin failures++; $display("FAIL last_addr_28 got %0d required 783", rd_addr); end
    endtask

    task automatic test_min_size();
        pulse_start(8, 2);
        tick();
        checks++; if (conv_ifmap_len !== 10'd63 || conv_ofmap_size !== 5'd1) begin failures++; $display("FAIL len_ofm_8 got %0d/%0d required 63/1", conv_ifmap_len, conv_ofmap_size); end
        checks++; if (conv_next_weight_row_jump !== 10'd1 || conv_next_ifmap_row_jump !== 10'd31 || conv_next_vector_jump !== 10'd35) begin failures++; $display("FAIL jumps_8 got %0d/%0d/%0d required 1/31/35", conv_next_weight_row_jump, conv_next_ifmap_row_jump, conv_next_vector_jump); end
        scan(8, 500, 1'b0);
        checks++; if (s_timeout !== 0 || s_nvalid !== 128 || s_addr_err !== 0) begin failures++; $display("FAIL stream_8 got to=%0d n=%0d errs=%0d required 0/128/0", s_timeout, s_nvalid, s_addr_err); end
        checks++; if (s_bubbles !== 1 || s_bubble_err !== 0) begin failures++; $display("FAIL bubble_8 got n=%0d bad=%0d required 1/0", s_bubbles, s_bubble_err); end
        checks++; if (s_chan_err !== 0 || channel_idx !== 4'd1) begin failures++; $display("FAIL chan_8 got errs=%0d idx=%0d required 0/1", s_chan_err, channel_idx); end
        checks++; if (s_ndone !== 1) begin failures++; $display("FAIL done_8 got %0d required 1", s_ndone); end
    endtask

    task automatic test_illegal();
        int sizes[4] = '{30, 36, 8, 8};
        int chans[4] = '{1, 1, 0, 17};
        for (int i = 0; i < 4; i++) begin
            pulse_start(sizes[i], chans[i]);
            checks++; if (cfg_error !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL illegal_%0d got err=%b busy=%b required 1/0", i, cfg_error, busy); end
            tick();
            checks++; if (cfg_error !== 1'b0 || conv_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL illegal_after_%0d got err=%b en=%b busy=%b required 0/0/0", i, cfg_error, conv_enable, busy); end
        end
    endtask

    task automatic test_full();
        pulse_start(32, 16);
        tick();
        checks++; if (conv_ifmap_len !== 10'd1023 || conv_ofmap_size !== 5'd7) begin failures++; $display("FAIL len_ofm_32 got %0d/%0d required 1023/7", conv_ifmap_len, conv_ofmap_size); end
        checks++; if (conv_next_weight_row_jump !== 10'd25 || conv_next_ifmap_row_jump !== 10'd127 || conv_next_vector_jump !== 10'd131) begin failures++; $display("FAIL jumps_32 got %0d/%0d/%0d required 25/127/131", conv_next_weight_row_jump, conv_next_ifmap_row_jump, conv_next_vector_jump); end
        scan(32, 20000, 1'b1);
        checks++; if (s_timeout !== 0 || s_nvalid !== 16384 || s_addr_err !== 0) begin failures++; $display("FAIL stream_32 got to=%0d n=%0d errs=%0d required 0/16384/0", s_timeout, s_nvalid, s_addr_err); end
        checks++; if (s_bubbles !== 15 || s_bubble_err !== 0 || s_chan_err !== 0) begin failures++; $display("FAIL bubbles_32 got n=%0d bad=%0d chan=%0d required 15/0/0", s_bubbles, s_bubble_err, s_chan_err); end
        checks++; if (rd_addr !== 14'd16383 || channel_idx !== 4'd15) begin failures++; $display("FAIL last_32 got addr=%0d ch=%0d required 16383/15", rd_addr, channel_idx); end
        checks++; if (s_ndone !== 1 || s_cfg_err_seen !== 0) begin failures++; $display("FAIL done_32 got done=%0d errs=%0d required 1/0", s_ndone, s_cfg_err_seen); end
    endtask

    task automatic test_abort();
        int waited;
        int seen_done;
        pulse_start(32, 16);
        waited = 0;
        while (!(rd_valid && rd_addr == 14'd5220) && waited < 8000) begin
            tick();
            waited++;
        end
        checks++; if (waited >= 8000 || channel_idx !== 4'd5) begin failures++; $display("FAIL abort_reach got waited=%0d ch=%0d required <8000/5", waited, channel_idx); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || rd_valid !== 1'b0 || conv_enable !== 1'b0 || conv_reset !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL abort_state got busy=%b vld=%b en=%b crst=%b done=%b required 0/0/0/1/0", busy, rd_valid, conv_enable, conv_reset, done); end
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done || cfg_error || busy) seen_done++;
        end
        checks++; if (seen_done !== 0) begin failures++; $display("FAIL abort_quiet got %0d required 0", seen_done); end
        pulse_start(8, 1);
        tick();
        scan(8, 500, 1'b0);
        checks++; if (s_timeout !== 0 || s_first_valid !== 1 || s_nvalid !== 64 || s_addr_err !== 0 || s_ndone !== 1) begin failures++; $display("FAIL restart got to=%0d first=%0d n=%0d errs=%0d done=%0d required 0/1/64/0/1", s_timeout, s_first_valid, s_nvalid, s_addr_err, s_ndone); end
    endtask

    task automatic test_reset_mid_run();
        pulse_start(28, 1);
        for (int i = 0; i < 50; i++) tick();
        checks++; if (rd_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_run_pre got vld=%b busy=%b required 1/1", rd_valid, busy); end
        reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || rd_valid !== 1'b0 || conv_enable !== 1'b0 || conv_reset !== 1'b1 || done !== 1'b0 || cfg_error !== 1'b0) begin failures++; $display("FAIL mid_reset_ctl got busy=%b vld=%b en=%b crst=%b done=%b err=%b", busy, rd_valid, conv_enable, conv_reset, done, cfg_error); end
        checks++; if (rd_addr !== 14'd0 || channel_idx !== 4'd0 || conv_ifmap_len !== 10'd0 || conv_ofmap_size !== 5'd0 || conv_next_weight_row_jump !== 10'd0 || conv_next_ifmap_row_jump !== 10'd0 || conv_next_vector_jump !== 10'd0) begin failures++; $display("FAIL mid_reset_data got addr=%0d ch=%0d len=%0d required 0", rd_addr, channel_idx, conv_ifmap_len); end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_legal_28();
        test_min_size();
        test_illegal();
        test_full();
        test_abort();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
